// File: rtl/branch_inst_encoder.sv
// Purpose: packs branch requests into RV32I B-type words, buffers them, tags each with a word address.
// Latency: a word accepted in cycle N can appear at the output in cycle N+1.
// Backpressure: in_ready drops while the FIFO is full (no same-cycle pass-through); out_ready stalls the head word and its address.
// Optional: define BRANCH_ENC_ILLEGAL_CHECK_EN to drop branch_control codes 2/3 and raise a sticky err flag.
module branch_inst_encoder #(
    parameter int                DEPTH     = 4,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [4:0]              rs1,
    input  logic [4:0]              rs2,
    input  logic [11:0]             imm,
    input  logic [2:0]              branch_control,
    input  logic                    addr_clr,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_instr,
    output logic [ADDR_W-1:0]       out_addr,
    output logic [$clog2(DEPTH):0]  fifo_level,
    output logic                    err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // Storage and bookkeeping
    logic [31:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             live;      // low until the first clock edge after reset release

    logic             full;
    logic             empty;
    logic             accept;
    logic             push;
    logic             pop;
    logic             illegal;
    logic [2:0]       func3;
    logic [31:0]      enc_word;

    // Codes 2 and 3 have no branch meaning in the shared macro encoding
    always_comb begin
        illegal = (branch_control == 3'd2) || (branch_control == 3'd3);
    end

`ifdef BRANCH_ENC_ILLEGAL_CHECK_EN
    // Illegal codes never reach the FIFO, so func3 can pass straight through
    always_comb begin
        func3 = branch_control;
    end
`else
    // Unused codes fall back to BEQ, the same default the decoder applies
    always_comb begin
        func3 = illegal ? 3'b000 : branch_control;
    end
`endif

    // B-type packing; imm carries offset bits [12:1], so imm[k] is offset bit k+1
    always_comb begin
        enc_word = {imm[11], imm[9:4], rs2, rs1, func3, imm[3:0], imm[10], OPC_BRANCH};
    end

    // Handshake decode; full/empty come from the level counter, not the pointers
    always_comb begin
        full      = (fifo_level == LVL_W'(DEPTH));
        empty     = (fifo_level == '0);
        in_ready  = live && !full;
        out_valid = !empty;
        accept    = in_valid && in_ready;
        pop       = out_valid && out_ready;
`ifdef BRANCH_ENC_ILLEGAL_CHECK_EN
        push      = accept && !illegal;
`else
        push      = accept;
`endif
        out_instr = empty ? 32'h0000_0000 : mem[rd_ptr];
    end

    // FIFO data array; contents behind the pointers are don't-care, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= enc_word;
        end
    end

    // Pointers and level; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Hold off in_ready for the first cycle after reset release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live <= 1'b0;
        end else begin
            live <= 1'b1;
        end
    end

    // Word address counter; a clear in the same cycle as a pop takes priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_addr <= BASE_ADDR;
        end else if (addr_clr) begin
            out_addr <= BASE_ADDR;
        end else if (pop) begin
            out_addr <= out_addr + ADDR_W'(4);
        end
    end

`ifdef BRANCH_ENC_ILLEGAL_CHECK_EN
    // Sticky flag for any handshaken request carrying an unused code
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (accept && illegal) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_branch_inst_encoder.sv
module tb_branch_inst_encoder;

    localparam int          DEPTH  = 4;
    localparam int          ADDR_W = 32;
    localparam logic [31:0] BASE   = 32'h0000_0100;
`ifdef BRANCH_ENC_ILLEGAL_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [11:0] imm;
    logic [2:0]  branch_control;
    logic        addr_clr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic [2:0]  fifo_level;
    logic        err;

    branch_inst_encoder #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .rs1(rs1), .rs2(rs2), .imm(imm), .branch_control(branch_control),
        .addr_clr(addr_clr), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr), .fifo_level(fifo_level),
        .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [11:0] imm;
        logic [2:0]  bc;
        logic        illegal;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs [8];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] q [$];
    logic [31:0] exp_addr;
    logic        exp_err;
    logic        rdy_ok;
    logic [31:0] cur_exp;
    logic        cur_illegal;

    task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Scoreboard: checks state each negedge, then models the coming posedge
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_out_valid", 32'(out_valid), 0);
            chk("rst_fifo_level", 32'(fifo_level), 0);
            chk("rst_in_ready", 32'(in_ready), 0);
            chk("rst_out_addr", out_addr, BASE);
            chk("rst_out_instr", out_instr, 0);
            chk("rst_err", 32'(err), 0);
            q.delete();
            exp_addr = BASE;
            exp_err  = 1'b0;
            rdy_ok   = 1'b0;
        end else begin
            automatic int  sz     = q.size();
            automatic bit  pop_m  = (sz != 0) && out_ready;
            automatic bit  push_m = in_valid && rdy_ok && (sz < DEPTH);
            chk("fifo_level", 32'(fifo_level), 32'(sz));
            chk("out_valid", 32'(out_valid), 32'(sz != 0));
            chk("in_ready", 32'(in_ready), 32'(rdy_ok && (sz < DEPTH)));
            chk("err", 32'(err), 32'(exp_err));
            chk("out_addr", out_addr, exp_addr);
            if (pop_m) begin
                chk("out_instr", out_instr, q[0]);
                void'(q.pop_front());
            end
            if (addr_clr) exp_addr = BASE;
            else if (pop_m) exp_addr = exp_addr + 32'd4;
            if (push_m) begin
                if (cur_illegal && CHK) exp_err = 1'b1;
                else q.push_back(cur_exp);
            end
            rdy_ok = 1'b1;
        end
    end

    task automatic drive(int idx);
        rs1            = vecs[idx].rs1;
        rs2            = vecs[idx].rs2;
        imm            = vecs[idx].imm;
        branch_control = vecs[idx].bc;
        cur_exp        = vecs[idx].exp;
        cur_illegal    = vecs[idx].illegal;
    endtask

    // Present one request until it is accepted (called just after a posedge)
    task automatic send(int idx);
        bit acc = 1'b0;
        int n   = 0;
        drive(idx);
        in_valid = 1'b1;
        while (!acc && n < 40) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        chk("send_timeout", 32'(acc), 1);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_timeout", 32'(q.size()), 0);
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{5'd1,  5'd2,  12'h004, 3'd0, 1'b0, 32'h00208463};
        vecs[1] = '{5'd5,  5'd6,  12'h800, 3'd1, 1'b0, 32'h80629063};
        vecs[2] = '{5'd3,  5'd4,  12'h000, 3'd4, 1'b0, 32'h0041C063};
        vecs[3] = '{5'd31, 5'd31, 12'hFFF, 3'd5, 1'b0, 32'hFFFFDFE3};
        vecs[4] = '{5'd0,  5'd0,  12'h400, 3'd6, 1'b0, 32'h000060E3};
        vecs[5] = '{5'd10, 5'd20, 12'h3F0, 3'd7, 1'b0, 32'h7F457063};
        vecs[6] = '{5'd7,  5'd9,  12'h00F, 3'd3, 1'b1, 32'h00938F63};
        vecs[7] = '{5'd2,  5'd3,  12'h001, 3'd2, 1'b1, 32'h00310163};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; addr_clr = 1'b0;
        drive(0);
        exp_addr = BASE; exp_err = 1'b0; rdy_ok = 1'b0;
        idle(3);
        rst = 1'b0;
        idle(1);

        // Single requests with idle gaps: latency and one-shot out_valid
        out_ready = 1'b1;
        send(0);
        idle(3);
        send(1);
        idle(3);
        // Legal table entries back to back
        for (int i = 2; i < 6; i++) send(i);
        drain();

        // Fill to full, then a fifth request waits through the first pop
        out_ready = 1'b0;
        for (int i = 2; i < 6; i++) send(i);
        idle(2);
        fork
            send(0);
            begin
                idle(4);
                out_ready = 1'b1;
            end
        join
        drain();

        // Continuous push and pop for 16 cycles
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive(i % 6);
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        drain();

        // addr_clr together with a pop, then on its own while stalled
        out_ready = 1'b0;
        send(1); send(2); send(3);
        out_ready = 1'b1; addr_clr = 1'b1;
        idle(1);
        out_ready = 1'b0; addr_clr = 1'b0;
        idle(1);
        addr_clr = 1'b1;
        idle(1);
        addr_clr = 1'b0;
        out_ready = 1'b1;
        drain();

        // Reset with three words buffered
        out_ready = 1'b0;
        send(3); send(4); send(5);
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 0);
        chk("async_rst_out_addr", out_addr, BASE);
        chk("async_rst_level", 32'(fifo_level), 0);
        idle(2);
        rst = 1'b0;
        idle(1);

        // Unused branch codes, followed by a legal request
        out_ready = 1'b1;
        send(6);
        send(7);
        send(0);
        drain();
        idle(3);
        chk("err_final", 32'(err), 32'(CHK));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_inst_encoder.md
Name: branch_inst_encoder

Overview:
- Encodes branch operations (rs1, rs2, 12-bit offset, branch_control) into 32-bit RV32I B-type instruction words.
- Inverse of the branch decode path. Feeds the instruction-memory loader used by self-checking program generation.
- Requests enter over a valid/ready handshake and are buffered in a FIFO.
- Encoded words leave with an auto-incrementing word address.

Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2.
- ADDR_W, 32, width of out_addr.
- BASE_ADDR, 32'h0000_0000, first address issued after reset or addr_clr.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  request can be accepted.
- rs1  input  5  source register 1.
- rs2  input  5  source register 2.
- imm  input  12  branch offset bits [12:1]; bit 0 implicitly 0.
- branch_control  input  3  shared branch macro encoding: BEQ=0, BNE=1, BLT=4, BGE=5, BLTU=6, BGEU=7; codes 2 and 3 unused.
- addr_clr  input  1  synchronous reload of the address counter to BASE_ADDR.
- out_valid  output  1  encoded word available.
- out_ready  input  1  consumer accepts the word.
- out_instr  output  32  encoded instruction.
- out_addr  output  ADDR_W  address for out_instr.
- fifo_level  output  $clog2(DEPTH)+1  occupied entries.
- err  output  1  sticky illegal-control flag (see Optional Feature).

Behaviour:
- Reset (async, rst=1): FIFO empty, fifo_level=0, out_valid=0, in_ready=0 while rst high, out_addr=BASE_ADDR, out_instr=0, err=0. in_ready rises the first cycle after rst deasserts.
- Encoding (combinational on input, written into FIFO on accept):
  - instr = {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], 7'b1100011}
  - func3 = branch_control for legal codes.
- Input handshake:
  - Accept when in_valid && in_ready.
  - in_ready = !full; no pass-through when full, even if a pop occurs that cycle.
- Output handshake:
  - out_valid = !empty. out_instr is the FIFO head; out_addr is the current counter.
  - On out_valid && out_ready: pop, and out_addr += 4, modulo 2^ADDR_W (wraps silently).
  - out_instr and out_addr hold stable while out_valid && !out_ready.
- Latency: a word accepted in cycle N appears with out_valid=1 in cycle N+1 at the earliest.
- Simultaneous push and pop (not full, not empty): level unchanged, both complete.
- addr_clr:
  - Counter loads BASE_ADDR next cycle.
  - If a pop occurs in the same cycle, addr_clr wins: the popped word used the old address, and the next word gets BASE_ADDR.
  - FIFO contents are unaffected.
- Pointers wrap modulo DEPTH; full/empty are derived from fifo_level.
- Reset mid-stream discards all buffered words.

Optional Feature:
- Macro BRANCH_ENC_ILLEGAL_CHECK_EN.
- Defined: branch_control 2 or 3 is still handshaken (in_ready unaffected), but nothing is written to the FIFO and err sets to 1 the next cycle. err stays set until rst.
- Undefined: codes 2 and 3 encode as BEQ (func3=000), matching the decoder default; err tied to 0.

Test Plan:
- Reset then single request (BEQ, rs1=1, rs2=2, imm=12'h004, out_ready=1) -> next cycle out_valid=1, out_instr=32'h00208463, out_addr=0; following cycle out_valid=0.
- BNE, rs1=5, rs2=6, imm=12'h800 -> out_instr=32'h80629063; next word's out_addr=+4.
- out_ready=0 with DEPTH=4: push 5 requests -> in_ready=0 after the 4th, fifo_level=4. Raise out_ready -> 4 words pop in order with addresses 0, 4, 8, 12, then the 5th is accepted.
- Continuous push and pop every cycle for 16 cycles -> fifo_level constant at 1, addresses increment by 4, no lost or duplicated words.
- addr_clr asserted mid-stream with BASE_ADDR=32'h100 -> next popped word carries 32'h100. rst asserted with 3 words buffered -> out_valid=0 immediately, out_addr=32'h100.
- branch_control=3 -> with BRANCH_ENC_ILLEGAL_CHECK_EN: no output word and err=1. Without it: out_instr func3 bits equal 000 and err=0.
